// File: rtl/minigpu_pkg.sv
// Shared minigpu definitions: control-unit state encodings, fetcher state
// encodings and default datapath widths.
package minigpu_pkg;

  localparam int PC_ADDR_WIDTH_DEF  = 8;
  localparam int INST_MSG_WIDTH_DEF = 16;

  typedef enum logic [3:0] {
    CU_IDLE    = 4'd0,
    CU_FETCH   = 4'd1,
    CU_DECODE  = 4'd2,
    CU_REQUEST = 4'd3,
    CU_WAIT    = 4'd4,
    CU_EXECUTE = 4'd5,
    CU_UPDATE  = 4'd6,
    CU_DONE    = 4'd7
  } cu_state_e;

  typedef enum logic [1:0] {
    FS_IDLE     = 2'd0,
    FS_FETCHING = 2'd1,
    FS_FETCHED  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetcher_icache_entry.sv
// Single-entry instruction cache: tag/data/valid register with hit compare.
// Only instantiated when FETCHER_ICACHE_EN is defined.
module fetcher_icache_entry
  import minigpu_pkg::*;
#(
  parameter int PC_ADDR_WIDTH  = PC_ADDR_WIDTH_DEF,
  parameter int INST_MSG_WIDTH = INST_MSG_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [PC_ADDR_WIDTH-1:0]  wr_tag,
  input  logic [INST_MSG_WIDTH-1:0] wr_data,
  input  logic [PC_ADDR_WIDTH-1:0]  lookup_tag,
  output logic                      hit,
  output logic [INST_MSG_WIDTH-1:0] hit_data
);

  logic [PC_ADDR_WIDTH-1:0]  tag_q, tag_d;
  logic [INST_MSG_WIDTH-1:0] data_q, data_d;
  logic                      valid_q, valid_d;

  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (wr_en) begin
      tag_d   = wr_tag;
      data_d  = wr_data;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign hit      = valid_q && (tag_q == lookup_tag);
  assign hit_data = data_q;

endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage: issues a program-memory read on FETCH and holds
// the word on instr for decode. Optional one-entry cache via FETCHER_ICACHE_EN.
module fetcher
  import minigpu_pkg::*;
#(
  parameter int PC_ADDR_WIDTH  = PC_ADDR_WIDTH_DEF,
  parameter int INST_MSG_WIDTH = INST_MSG_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                cu_state,
  input  logic [PC_ADDR_WIDTH-1:0]  pc,
  output logic                      mem_read_valid,
  output logic [PC_ADDR_WIDTH-1:0]  mem_read_address,
  input  logic                      mem_read_ready,
  input  logic [INST_MSG_WIDTH-1:0] mem_read_data,
  output logic [1:0]                fetcher_state,
  output logic [INST_MSG_WIDTH-1:0] instr
);

  fetch_state_e              state_q, state_d;
  logic                      valid_q, valid_d;
  logic [PC_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [INST_MSG_WIDTH-1:0] instr_q, instr_d;

  logic                      is_fetch, is_decode, fill;
  logic                      hit;
  logic [INST_MSG_WIDTH-1:0] hit_data;

  assign is_fetch  = (cu_state == CU_FETCH);
  assign is_decode = (cu_state == CU_DECODE);
  assign fill      = (state_q == FS_FETCHING) && mem_read_ready;

`ifdef FETCHER_ICACHE_EN
  // Fill uses the latched request address, not the live pc.
  fetcher_icache_entry #(
    .PC_ADDR_WIDTH (PC_ADDR_WIDTH),
    .INST_MSG_WIDTH(INST_MSG_WIDTH)
  ) u_icache (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (fill),
    .wr_tag    (addr_q),
    .wr_data   (mem_read_data),
    .lookup_tag(pc),
    .hit       (hit),
    .hit_data  (hit_data)
  );
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FS_IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_IDLE:     if (is_fetch) state_d = hit ? FS_FETCHED : FS_FETCHING;
      FS_FETCHING: if (mem_read_ready) state_d = FS_FETCHED;
      FS_FETCHED:  if (is_decode) state_d = FS_IDLE;
      default:     state_d = FS_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    case (state_q)
      FS_IDLE: begin
        if (is_fetch) begin
          if (hit) begin
            instr_d = hit_data;
          end else begin
            valid_d = 1'b1;
            addr_d  = pc;
          end
        end
      end
      FS_FETCHING: begin
        if (mem_read_ready) begin
          instr_d = mem_read_data;
          valid_d = 1'b0;
        end
      end
      FS_FETCHED: ;
      default: valid_d = 1'b0;
    endcase
  end

  assign mem_read_valid   = valid_q;
  assign mem_read_address = addr_q;
  assign fetcher_state    = state_q;
  assign instr            = instr_q;

endmodule

// File: tb/tb_fetcher.sv
// Directed-vector bench for fetcher; cache expectations follow FETCHER_ICACHE_EN.
module tb_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cu_state;
  logic [7:0]  pc;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [1:0]  fetcher_state;
  logic [15:0] instr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetcher dut (
    .clk             (clk),
    .reset           (reset),
    .cu_state        (cu_state),
    .pc              (pc),
    .mem_read_valid  (mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready  (mem_read_ready),
    .mem_read_data   (mem_read_data),
    .fetcher_state   (fetcher_state),
    .instr           (instr)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  cu;
    logic [7:0]  pc;
    logic        rdy;
    logic [15:0] data;
    logic        e_valid;
    logic [7:0]  e_addr;
    logic [1:0]  e_state;
    logic [15:0] e_instr;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] cu, input logic [7:0] p,
                      input logic rdy, input logic [15:0] d);
    reset = r; cu_state = cu; pc = p; mem_read_ready = rdy; mem_read_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic v, input logic [7:0] a,
                         input logic [1:0] s, input logic [15:0] i);
    chk({nm, ".valid"}, {15'd0, mem_read_valid}, {15'd0, v});
    chk({nm, ".addr"},  {8'd0, mem_read_address}, {8'd0, a});
    chk({nm, ".state"}, {14'd0, fetcher_state}, {14'd0, s});
    chk({nm, ".instr"}, instr, i);
  endtask

  initial begin
    //          name         rst cu     pc     rdy data      valid addr   st    instr
    vecs[0]  = '{"fetch_req",  0, 4'd1, 8'h05, 0, 16'h0000,  1, 8'h05, 2'd1, 16'h0000};
    vecs[1]  = '{"pc_chg1",    0, 4'd1, 8'h09, 0, 16'hBEEF,  1, 8'h05, 2'd1, 16'h0000};
    vecs[2]  = '{"pc_chg2",    0, 4'd4, 8'h09, 0, 16'hBEEF,  1, 8'h05, 2'd1, 16'h0000};
    vecs[3]  = '{"resp",       0, 4'd4, 8'h09, 1, 16'h3A12,  0, 8'h05, 2'd2, 16'h3A12};
    vecs[4]  = '{"hold_fd",    0, 4'd5, 8'h09, 0, 16'h0000,  0, 8'h05, 2'd2, 16'h3A12};
    vecs[5]  = '{"decode",     0, 4'd2, 8'h09, 0, 16'h0000,  0, 8'h05, 2'd0, 16'h3A12};
    vecs[6]  = '{"idle_rdy",   0, 4'd0, 8'h09, 1, 16'hFFFF,  0, 8'h05, 2'd0, 16'h3A12};
    vecs[7]  = '{"cu15_rdy",   0, 4'd15,8'h09, 1, 16'hFFFF,  0, 8'h05, 2'd0, 16'h3A12};
    vecs[8]  = '{"b2b_req",    0, 4'd1, 8'h07, 0, 16'h0000,  1, 8'h07, 2'd1, 16'h3A12};
    vecs[9]  = '{"b2b_resp",   0, 4'd3, 8'h07, 1, 16'h1111,  0, 8'h07, 2'd2, 16'h1111};
    vecs[10] = '{"b2b_dec",    0, 4'd2, 8'h07, 0, 16'h0000,  0, 8'h07, 2'd0, 16'h1111};
    vecs[11] = '{"req3",       0, 4'd1, 8'h08, 0, 16'h0000,  1, 8'h08, 2'd1, 16'h1111};
    vecs[12] = '{"rst_mid",    1, 4'd4, 8'h08, 1, 16'h1234,  0, 8'h00, 2'd0, 16'h0000};
    vecs[13] = '{"post_rst",   0, 4'd0, 8'h08, 0, 16'h1234,  0, 8'h00, 2'd0, 16'h0000};

    step(1, 4'd0, 8'h00, 0, 16'h0000);
    step(1, 4'd0, 8'h00, 0, 16'h0000);
    chk_all("reset", 0, 8'h00, 2'd0, 16'h0000);
    for (int c = 0; c < 10; c++) begin
      step(0, 4'd0, 8'h00, 0, 16'h0000);
      chk({"idle", $sformatf("%0d", c), ".valid"}, {15'd0, mem_read_valid}, 16'd0);
      chk({"idle", $sformatf("%0d", c), ".state"}, {14'd0, fetcher_state}, 16'd0);
      chk({"idle", $sformatf("%0d", c), ".instr"}, instr, 16'h0000);
    end

    for (int k = 0; k < 14; k++) begin
      step(vecs[k].rst, vecs[k].cu, vecs[k].pc, vecs[k].rdy, vecs[k].data);
      chk_all(vecs[k].name, vecs[k].e_valid, vecs[k].e_addr, vecs[k].e_state, vecs[k].e_instr);
    end

    // Refetch of the same pc: hits the cache entry when present.
    step(0, 4'd1, 8'h05, 0, 16'h0000);
    chk_all("c_req", 1, 8'h05, 2'd1, 16'h0000);
    step(0, 4'd4, 8'h05, 1, 16'h3A12);
    chk_all("c_fill", 0, 8'h05, 2'd2, 16'h3A12);
    step(0, 4'd2, 8'h05, 0, 16'h0000);
    chk_all("c_dec", 0, 8'h05, 2'd0, 16'h3A12);
    step(0, 4'd1, 8'h05, 1, 16'h7777);
`ifdef FETCHER_ICACHE_EN
    chk("c_hit.valid", {15'd0, mem_read_valid}, 16'd0);
    chk("c_hit.state", {14'd0, fetcher_state}, 16'd2);
    chk("c_hit.instr", instr, 16'h3A12);
    step(0, 4'd2, 8'h05, 0, 16'h0000);
    chk("c_hit_dec.state", {14'd0, fetcher_state}, 16'd0);
`else
    chk_all("c_nohit", 1, 8'h05, 2'd1, 16'h3A12);
    step(0, 4'd4, 8'h05, 1, 16'h5555);
    chk_all("c_nohit_resp", 0, 8'h05, 2'd2, 16'h5555);
    step(0, 4'd2, 8'h05, 0, 16'h0000);
    chk("c_nohit_dec.state", {14'd0, fetcher_state}, 16'd0);
`endif
    step(0, 4'd1, 8'h06, 0, 16'h0000);
    chk("c_miss.valid", {15'd0, mem_read_valid}, 16'd1);
    chk("c_miss.addr",  {8'd0, mem_read_address}, 16'h0006);
    chk("c_miss.state", {14'd0, fetcher_state}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetcher.md
# fetcher

Instruction fetch stage of the minigpu core. It sits directly upstream of the decoder. On the core control unit's FETCH state it requests the 16-bit instruction at the current PC from program memory over a valid/ready read handshake, then holds that word stable on `instr` for the decoder through the DECODE state. It reports its own state so the control unit knows when to advance from FETCH to DECODE.

## Interface
Parameters:
- `PC_ADDR_WIDTH`, default 8: program-memory address width.
- `INST_MSG_WIDTH`, default 16: instruction width.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `cu_state`, input, 4: core control-unit state.
- `pc`, input, PC_ADDR_WIDTH: address to fetch; sampled in FETCH.
- `mem_read_valid`, output, 1: read request to program memory.
- `mem_read_address`, output, PC_ADDR_WIDTH: request address.
- `mem_read_ready`, input, 1: memory response strobe; data is valid this cycle.
- `mem_read_data`, input, INST_MSG_WIDTH: instruction word from memory.
- `fetcher_state`, output, 2: IDLE=0, FETCHING=1, FETCHED=2.
- `instr`, output, INST_MSG_WIDTH: instruction to the decoder.

## Operation
- `cu_state` encodings: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7. Values 8–15 are treated as non-FETCH and non-DECODE.
- Reset values: `fetcher_state`=IDLE, `mem_read_valid`=0, `mem_read_address`=0, `instr`=0.
- **IDLE**
  - If `cu_state`==FETCH: set `mem_read_valid`=1 and `mem_read_address`=`pc`, then go to FETCHING.
  - Otherwise: hold.
  - `mem_read_ready` is ignored in IDLE.
- **FETCHING**
  - `mem_read_valid` and `mem_read_address` are held constant until `mem_read_ready`=1.
  - On `mem_read_ready`=1:
    - `instr` <= `mem_read_data`.
    - `mem_read_valid` <= 0.
    - Go to FETCHED.
  - `pc` changes during FETCHING are ignored; the address was latched on entry.
- **FETCHED**
  - `instr` is held.
  - If `cu_state`==DECODE: go to IDLE. `instr` keeps its value until the next completed fetch.
  - Otherwise: hold.
- There is no timeout. FETCHING waits indefinitely for `mem_read_ready`.
- `instr` changes only on fetch completion or reset.
- State encoding 3 is unreachable. If it is ever entered, the next edge forces IDLE with `mem_read_valid`=0.

## Timing
- Request latency: `mem_read_valid` rises on the first edge after `cu_state`==FETCH is sampled in IDLE.
- Minimum fetch latency: memory asserts `mem_read_ready` in the first FETCHING cycle. `instr` and FETCHED are then visible one cycle later, so FETCH→FETCHED takes 2 cycles.
- FETCHED→IDLE takes 1 edge after DECODE is sampled.
- Reset mid-fetch: all outputs return to their reset values on that edge. A `mem_read_ready` in the same cycle is dropped, and `instr` stays 0.
- Back-to-back fetches: FETCH sampled on the cycle after returning to IDLE starts a new request immediately. There are no bubble requirements.

## Configuration
- `FETCHER_ICACHE_EN` compiled in:
  - Adds a one-entry tag+data register: tag PC_ADDR_WIDTH bits, data INST_MSG_WIDTH bits, plus a valid bit cleared by reset.
  - Every completed fetch writes the entry.
  - In IDLE with FETCH and `pc`==tag and valid set: go straight to FETCHED. `instr` <= cached data, no memory request is issued, and latency is 1 cycle.
  - On a miss: normal behaviour.
- `FETCHER_ICACHE_EN` compiled out: every FETCH issues a memory request. No cache state exists.

## Structure
- Shared package `minigpu_pkg` holds:
  - the `cu_state` encodings (shared with the decoder and control unit);
  - the fetcher state encodings;
  - the default widths.
- Sub-module `fetcher_icache_entry` holds the tag/data/valid register and hit compare. It is instantiated only under `FETCHER_ICACHE_EN`. All other logic is a single FSM in `fetcher`.

## Test plan
- Reset, then hold `cu_state`=IDLE → `mem_read_valid`=0, `instr`=0x0000, `fetcher_state`=0 for 10 cycles.
- `pc`=0x05, FETCH, memory returns ready with 0x3A12 after 3 cycles → valid high and address 0x05 held for exactly 3 cycles; `instr`=0x3A12; state 2; state 0 one cycle after DECODE.
- `mem_read_ready` pulsed while IDLE with data 0xFFFF → no state change, `instr` unchanged.
- `pc` changed 0x05→0x09 during FETCHING → `mem_read_address` stays 0x05.
- Reset asserted in FETCHING with ready and 0x1234 in the same cycle → state 0, valid 0, `instr`=0x0000.
- `FETCHER_ICACHE_EN`: fetch 0x05 (returns 0x3A12), DECODE, then FETCH 0x05 again → no `mem_read_valid`, FETCHED after 1 cycle, `instr`=0x3A12. FETCH 0x06 → request issued.
